// File: rtl/battle_pkg.sv
// Shared encodings and helpers for the battle turn controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package battle_pkg;

  // Default strike window length and approach timeout, in core cycles.
  localparam int STRIKE_CYCLES_DEF    = 4;
  localparam int APPROACH_TIMEOUT_DEF = 200;

  // FSM state encoding; the numeric values are exposed on state_dbg.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SELECT    = 3'd1,
    ST_APPROACH  = 3'd2,
    ST_STRIKE    = 3'd3,
    ST_RESOLVE   = 3'd4,
    ST_GAME_OVER = 3'd5
  } state_t;

  // Weapon encoding shared with the damage engine.
  typedef enum logic [1:0] {
    WPN_FIST  = 2'b00,
    WPN_SWORD = 2'b01,
    WPN_BAT   = 2'b10,
    WPN_KICK  = 2'b11
  } weapon_t;

  // Enemy LFSR: seed and tap mask for taps 8,6,5,4 (bits 7,5,4,3).
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  // Next player weapon in the rotation, skipping weapons with no ammo.
  // Fist and kick are always available, so the rotation never stalls.
  function automatic logic [1:0] next_player_weapon(input logic [1:0] cur,
                                                    input logic       sword_ok,
                                                    input logic       bat_ok);
    logic [1:0] nxt;
    nxt = cur + 2'd1;
    if (nxt == WPN_SWORD && !sword_ok) nxt = WPN_BAT;
    if (nxt == WPN_BAT   && !bat_ok)   nxt = WPN_KICK;
    return nxt;
  endfunction

  // Enemy weapon from the random draw; an empty weapon falls back to fist.
  function automatic logic [1:0] enemy_draw(input logic [1:0] raw,
                                            input logic       sword_ok,
                                            input logic       bat_ok);
    logic [1:0] pick;
    pick = raw;
    if (pick == WPN_SWORD && !sword_ok) pick = WPN_FIST;
    if (pick == WPN_BAT   && !bat_ok)   pick = WPN_FIST;
    return pick;
  endfunction

endpackage

// File: rtl/enemy_lfsr8.sv
// 8-bit Fibonacci LFSR used as the enemy's weapon dice; free-runs every cycle.
// Latency: value updates one cycle after each rising clock edge.
// Backpressure: none; it never stalls and has no handshake.
module enemy_lfsr8
  import battle_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] value
);

  logic [7:0] r_value;
  logic       w_feedback;

  assign w_feedback = ^(r_value & LFSR_TAPS);

  // Shift left each cycle, inserting the XOR of the tapped bits at bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= LFSR_SEED;
    end else begin
      r_value <= {r_value[6:0], w_feedback};
    end
  end

  assign value = r_value;

endmodule

// File: rtl/battle_turn_controller.sv
// Turn sequencer for a two-fighter battle: weapon select, approach, strike window, resolve.
// Latency: all outputs registered; strike opens the cycle after sprite_contact is seen.
// Backpressure: none; buttons are edge events and the engine is paced by collision_detected.
module battle_turn_controller
  import battle_pkg::*;
#(
  parameter int STRIKE_CYCLES    = STRIKE_CYCLES_DEF,
  parameter int APPROACH_TIMEOUT = APPROACH_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_select,
  input  logic       btn_confirm,
  input  logic       sprite_contact,
  input  logic       player_win,
  input  logic       enemy_win,
  input  logic [4:0] player_remained_sword,
  input  logic [4:0] player_remained_baseballbat,
  input  logic [4:0] enemy_remained_sword,
  input  logic [4:0] enemy_remained_baseballbat,
  output logic       collision_detected,
  output logic [1:0] player_choice,
  output logic [1:0] enemy_choice,
  output logic       player_turn,
  output logic       attacker_turn,
  output logic [7:0] turn_count,
  output logic       game_over,
  output logic [2:0] state_dbg
);

  localparam int SW = (STRIKE_CYCLES > 1) ? $clog2(STRIKE_CYCLES) : 1;
  localparam int TW = (APPROACH_TIMEOUT > 1) ? $clog2(APPROACH_TIMEOUT) : 1;
  localparam logic [SW-1:0] STRIKE_LAST = SW'(STRIKE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(APPROACH_TIMEOUT - 1);

  // Registered state and outputs.
  state_t        r_state;
  logic          r_coll;
  logic [1:0]    r_player;
  logic [1:0]    r_enemy;
  logic          r_turn;
  logic [7:0]    r_turn_count;
  logic          r_game_over;
  logic [SW-1:0] r_strike_cnt;
  logic [TW-1:0] r_to_cnt;
  // Win reported by the engine at any time since the last resolve.
  logic          r_win_pend;
  // Previous button levels for rising-edge detection.
  logic          r_sel_prev;
  logic          r_conf_prev;

  logic [7:0]    w_lfsr;
  logic          w_lfsr_unused;
  logic          w_sel_edge;
  logic          w_conf_edge;
  logic          w_p_sword_ok;
  logic          w_p_bat_ok;
  logic          w_e_sword_ok;
  logic          w_e_bat_ok;
  logic          w_win_now;
  logic          w_win;

  enemy_lfsr8 u_enemy_lfsr8 (
    .clk   (clk),
    .rst   (rst),
    .value (w_lfsr)
  );

  // Only the low two bits pick the enemy weapon; the rest just feed the shift.
  assign w_lfsr_unused = ^w_lfsr[7:2];

  assign w_sel_edge   = btn_select  & ~r_sel_prev;
  assign w_conf_edge  = btn_confirm & ~r_conf_prev;
  assign w_p_sword_ok = |player_remained_sword;
  assign w_p_bat_ok   = |player_remained_baseballbat;
  assign w_e_sword_ok = |enemy_remained_sword;
  assign w_e_bat_ok   = |enemy_remained_baseballbat;
  assign w_win_now    = player_win | enemy_win;
  assign w_win        = r_win_pend | w_win_now;

  // Remember last button levels so a held button yields a single event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel_prev  <= 1'b0;
      r_conf_prev <= 1'b0;
    end else begin
      r_sel_prev  <= btn_select;
      r_conf_prev <= btn_confirm;
    end
  end

  // Main turn FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_coll       <= 1'b0;
      r_player     <= WPN_FIST;
      r_enemy      <= WPN_FIST;
      r_turn       <= 1'b0;
      r_turn_count <= 8'd0;
      r_game_over  <= 1'b0;
      r_strike_cnt <= '0;
      r_to_cnt     <= '0;
      r_win_pend   <= 1'b0;
    end else begin
      // A win flag pulsed mid-turn is held until the next resolve.
      r_win_pend <= r_win_pend | w_win_now;
      case (r_state)
        ST_IDLE: begin
          // Stale flags from a previous game must not end the new one.
          r_win_pend <= 1'b0;
          if (w_conf_edge) begin
            r_turn  <= 1'b1;
            r_state <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          // Confirm has priority; a coincident select is dropped.
          if (w_conf_edge) begin
            r_enemy  <= enemy_draw(w_lfsr[1:0], w_e_sword_ok, w_e_bat_ok);
            r_to_cnt <= '0;
            r_state  <= ST_APPROACH;
          end else if (w_sel_edge) begin
            r_player <= next_player_weapon(r_player, w_p_sword_ok, w_p_bat_ok);
          end
        end
        ST_APPROACH: begin
          // Contact wins over a timeout landing on the same cycle.
          if (sprite_contact) begin
            r_coll       <= 1'b1;
            r_strike_cnt <= '0;
            r_state      <= ST_STRIKE;
          end else if (r_to_cnt == TIMEOUT_LAST) begin
            r_state <= ST_RESOLVE;
          end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
          end
        end
        ST_STRIKE: begin
          if (r_strike_cnt == STRIKE_LAST) begin
            r_coll  <= 1'b0;
            r_state <= ST_RESOLVE;
          end else begin
            r_strike_cnt <= r_strike_cnt + SW'(1);
          end
        end
        ST_RESOLVE: begin
          if (w_win) begin
            r_game_over <= 1'b1;
            r_state     <= ST_GAME_OVER;
          end else begin
            r_turn <= ~r_turn;
            if (r_turn_count != 8'hFF) begin
              r_turn_count <= r_turn_count + 8'd1;
            end
            r_state <= ST_SELECT;
          end
        end
        ST_GAME_OVER: begin
          if (w_conf_edge) begin
            r_game_over  <= 1'b0;
            r_turn_count <= 8'd0;
            r_player     <= WPN_FIST;
            r_enemy      <= WPN_FIST;
            r_win_pend   <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign collision_detected = r_coll;
  assign player_choice      = r_player;
  assign enemy_choice       = r_enemy;
  assign player_turn        = r_turn;
  assign attacker_turn      = r_turn;
  assign turn_count         = r_turn_count;
  assign game_over          = r_game_over;
  assign state_dbg          = r_state;

endmodule

// File: tb/tb_battle_turn_controller.sv
// Self-checking bench for battle_turn_controller with an expected-strike scoreboard.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_battle_turn_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_select;
  logic       btn_confirm;
  logic       sprite_contact;
  logic       player_win;
  logic       enemy_win;
  logic [4:0] player_remained_sword;
  logic [4:0] player_remained_baseballbat;
  logic [4:0] enemy_remained_sword;
  logic [4:0] enemy_remained_baseballbat;
  logic       collision_detected;
  logic [1:0] player_choice;
  logic [1:0] enemy_choice;
  logic       player_turn;
  logic       attacker_turn;
  logic [7:0] turn_count;
  logic       game_over;
  logic [2:0] state_dbg;

  typedef struct packed {
    logic [1:0] pc;
    logic [1:0] ec;
    logic       turn;
  } strike_t;

  strike_t    exp_q[$];
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_tc;
  logic       exp_turn;
  logic [1:0] exp_pc;
  logic [7:0] m_lfsr;

  battle_turn_controller #(
    .STRIKE_CYCLES    (4),
    .APPROACH_TIMEOUT (200)
  ) dut (
    .clk                         (clk),
    .rst                         (rst),
    .btn_select                  (btn_select),
    .btn_confirm                 (btn_confirm),
    .sprite_contact              (sprite_contact),
    .player_win                  (player_win),
    .enemy_win                   (enemy_win),
    .player_remained_sword       (player_remained_sword),
    .player_remained_baseballbat (player_remained_baseballbat),
    .enemy_remained_sword        (enemy_remained_sword),
    .enemy_remained_baseballbat  (enemy_remained_baseballbat),
    .collision_detected          (collision_detected),
    .player_choice               (player_choice),
    .enemy_choice                (enemy_choice),
    .player_turn                 (player_turn),
    .attacker_turn               (attacker_turn),
    .turn_count                  (turn_count),
    .game_over                   (game_over),
    .state_dbg                   (state_dbg)
  );

  always #5 clk = ~clk;

  // Reference LFSR: seed A5, taps 8,6,5,4.
  always @(posedge clk) begin
    if (rst) m_lfsr <= 8'hA5;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  function automatic logic [1:0] exp_enemy(input logic [7:0] lf, input logic [4:0] s, input logic [4:0] b);
    logic [1:0] r;
    r = lf[1:0];
    if (r == 2'b01 && s == 5'd0) r = 2'b00;
    if (r == 2'b10 && b == 5'd0) r = 2'b00;
    return r;
  endfunction

  // Confirm press (optionally with a simultaneous select); pushes the expected strike.
  task automatic confirm_go(input bit push, input bit with_sel, input logic [1:0] pc, input logic turn);
    strike_t e;
    @(negedge clk);
    btn_confirm = 1'b1;
    btn_select  = with_sel;
    if (push) begin
      e.pc   = pc;
      e.ec   = exp_enemy(m_lfsr, enemy_remained_sword, enemy_remained_baseballbat);
      e.turn = turn;
      exp_q.push_back(e);
    end
    @(negedge clk);
    btn_confirm = 1'b0;
    btn_select  = 1'b0;
  endtask

  task automatic press_select();
    @(negedge clk);
    btn_select = 1'b1;
    @(negedge clk);
    btn_select = 1'b0;
  endtask

  // Called in APPROACH; drives contact, compares the strike against the scoreboard.
  task automatic run_strike(input int win_at);
    strike_t e;
    int      len;
    sprite_contact = 1'b1;
    @(negedge clk);
    checks++;
    if (collision_detected !== 1'b1 || state_dbg !== 3'd3) begin
      failures++;
      $display("FAIL strike_start: coll=%b state=%0d expected coll=1 state=3", collision_detected, state_dbg);
    end
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty: queue size=0 expected an entry");
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    len = 0;
    while (collision_detected === 1'b1 && len < 16) begin
      checks++;
      if ({player_choice, enemy_choice, player_turn, attacker_turn} !== {e.pc, e.ec, e.turn, e.turn}) begin
        failures++;
        $display("FAIL strike_outputs: pc=%b ec=%b pt=%b at=%b expected pc=%b ec=%b turn=%b",
                 player_choice, enemy_choice, player_turn, attacker_turn, e.pc, e.ec, e.turn);
      end
      enemy_win = (len == win_at);
      len++;
      @(negedge clk);
    end
    enemy_win      = 1'b0;
    sprite_contact = 1'b0;
    checks++;
    if (len != 4) begin
      failures++;
      $display("FAIL strike_length: got=%0d expected 4", len);
    end
    checks++;
    if (state_dbg !== 3'd4 || collision_detected !== 1'b0) begin
      failures++;
      $display("FAIL resolve_state: state=%0d coll=%b expected state=4 coll=0", state_dbg, collision_detected);
    end
  endtask

  // Called in RESOLVE when no win is pending; expects return to SELECT.
  task automatic check_round();
    if (exp_tc != 8'hFF) exp_tc = exp_tc + 8'd1;
    exp_turn = ~exp_turn;
    @(negedge clk);
    checks++;
    if ({state_dbg, turn_count, player_turn, attacker_turn} !== {3'd1, exp_tc, exp_turn, exp_turn}) begin
      failures++;
      $display("FAIL round_end: state=%0d tc=%0d turn=%b/%b expected state=1 tc=%0d turn=%b",
               state_dbg, turn_count, player_turn, attacker_turn, exp_tc, exp_turn);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({state_dbg, collision_detected, game_over, turn_count} !== {3'd0, 1'b0, 1'b0, 8'd0}) begin
      failures++;
      $display("FAIL reset_state: state=%0d coll=%b go=%b tc=%0d expected 0 0 0 0",
               state_dbg, collision_detected, game_over, turn_count);
    end
    checks++;
    if ({player_choice, enemy_choice, player_turn, attacker_turn} !== 6'b0) begin
      failures++;
      $display("FAIL reset_choices: pc=%b ec=%b pt=%b at=%b expected all 0",
               player_choice, enemy_choice, player_turn, attacker_turn);
    end
    rst = 1'b0;
  endtask

  task automatic test_first_strike();
    confirm_go(1'b0, 1'b0, 2'b00, 1'b0);
    exp_tc = 8'd0; exp_turn = 1'b1; exp_pc = 2'b00;
    checks++;
    if ({state_dbg, player_turn, attacker_turn} !== {3'd1, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL idle_to_select: state=%0d pt=%b at=%b expected 1 1 1", state_dbg, player_turn, attacker_turn);
    end
    confirm_go(1'b1, 1'b0, exp_pc, exp_turn);
    checks++;
    if (state_dbg !== 3'd2) begin
      failures++;
      $display("FAIL select_to_approach: state=%0d expected 2", state_dbg);
    end
    run_strike(-1);
    check_round();
  endtask

  task automatic test_select_skip();
    logic [1:0] seq_a [3];
    logic [1:0] seq_b [3];
    logic [1:0] seq_c [2];
    seq_a = '{2'b10, 2'b11, 2'b00};
    seq_b = '{2'b01, 2'b11, 2'b00};
    seq_c = '{2'b11, 2'b00};
    player_remained_sword = 5'd0; player_remained_baseballbat = 5'd5;
    for (int i = 0; i < 3; i++) begin
      press_select();
      checks++;
      if (player_choice !== seq_a[i]) begin
        failures++;
        $display("FAIL skip_sword[%0d]: pc=%b expected %b", i, player_choice, seq_a[i]);
      end
    end
    player_remained_sword = 5'd5; player_remained_baseballbat = 5'd0;
    for (int i = 0; i < 3; i++) begin
      press_select();
      checks++;
      if (player_choice !== seq_b[i]) begin
        failures++;
        $display("FAIL skip_bat[%0d]: pc=%b expected %b", i, player_choice, seq_b[i]);
      end
    end
    player_remained_sword = 5'd0;
    for (int i = 0; i < 2; i++) begin
      press_select();
      checks++;
      if (player_choice !== seq_c[i]) begin
        failures++;
        $display("FAIL skip_both[%0d]: pc=%b expected %b", i, player_choice, seq_c[i]);
      end
    end
    player_remained_sword = 5'd5; player_remained_baseballbat = 5'd5;
    // A held button must advance exactly once.
    @(negedge clk);
    btn_select = 1'b1;
    repeat (5) @(negedge clk);
    btn_select = 1'b0;
    checks++;
    if (player_choice !== 2'b01) begin
      failures++;
      $display("FAIL held_select: pc=%b expected 01", player_choice);
    end
    exp_pc = 2'b01;
  endtask

  task automatic test_same_cycle();
    confirm_go(1'b1, 1'b1, exp_pc, exp_turn);
    checks++;
    if ({state_dbg, player_choice} !== {3'd2, 2'b01}) begin
      failures++;
      $display("FAIL same_cycle: state=%0d pc=%b expected state=2 pc=01", state_dbg, player_choice);
    end
    run_strike(-1);
    check_round();
  endtask

  task automatic test_enemy_zero_ammo();
    enemy_remained_sword = 5'd0; enemy_remained_baseballbat = 5'd0;
    for (int i = 0; i < 3; i++) begin
      confirm_go(1'b1, 1'b0, exp_pc, exp_turn);
      checks++;
      if (enemy_choice !== 2'b00) begin
        failures++;
        $display("FAIL enemy_no_ammo[%0d]: ec=%b expected 00", i, enemy_choice);
      end
      run_strike(-1);
      check_round();
    end
    enemy_remained_sword = 5'd5; enemy_remained_baseballbat = 5'd5;
  endtask

  task automatic test_timeout();
    int n;
    bit saw;
    // Late contact leaves the counter partly used; next entry must start from zero.
    confirm_go(1'b1, 1'b0, exp_pc, exp_turn);
    repeat (149) @(negedge clk);
    checks++;
    if (state_dbg !== 3'd2) begin
      failures++;
      $display("FAIL approach_hold: state=%0d expected 2", state_dbg);
    end
    run_strike(-1);
    check_round();
    confirm_go(1'b0, 1'b0, exp_pc, exp_turn);
    n = 0; saw = 1'b0;
    while (state_dbg === 3'd2 && n < 400) begin
      if (collision_detected !== 1'b0) saw = 1'b1;
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 200) begin
      failures++;
      $display("FAIL timeout_len: approach cycles=%0d expected 200", n);
    end
    checks++;
    if (saw || state_dbg !== 3'd4 || collision_detected !== 1'b0) begin
      failures++;
      $display("FAIL timeout_resolve: pulse=%b state=%0d coll=%b expected pulse=0 state=4 coll=0",
               saw, state_dbg, collision_detected);
    end
    check_round();
  endtask

  task automatic test_win();
    confirm_go(1'b1, 1'b0, exp_pc, exp_turn);
    run_strike(1);
    @(negedge clk);
    checks++;
    if ({state_dbg, game_over, turn_count, collision_detected} !== {3'd5, 1'b1, exp_tc, 1'b0}) begin
      failures++;
      $display("FAIL game_over_entry: state=%0d go=%b tc=%0d coll=%b expected 5 1 %0d 0",
               state_dbg, game_over, turn_count, collision_detected, exp_tc);
    end
    press_select();
    repeat (3) @(negedge clk);
    checks++;
    if ({state_dbg, game_over, player_choice, player_turn} !== {3'd5, 1'b1, exp_pc, exp_turn}) begin
      failures++;
      $display("FAIL game_over_hold: state=%0d go=%b pc=%b pt=%b expected 5 1 %b %b",
               state_dbg, game_over, player_choice, player_turn, exp_pc, exp_turn);
    end
    confirm_go(1'b0, 1'b0, 2'b00, 1'b0);
    checks++;
    if ({state_dbg, game_over, turn_count, player_choice, enemy_choice} !== {3'd0, 1'b0, 8'd0, 2'b00, 2'b00}) begin
      failures++;
      $display("FAIL restart_idle: state=%0d go=%b tc=%0d pc=%b ec=%b expected 0 0 0 00 00",
               state_dbg, game_over, turn_count, player_choice, enemy_choice);
    end
  endtask

  task automatic test_reset_mid_strike();
    strike_t e;
    bit      bad;
    confirm_go(1'b0, 1'b0, 2'b00, 1'b0);
    confirm_go(1'b1, 1'b0, 2'b00, 1'b1);
    sprite_contact = 1'b1;
    @(negedge clk);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    checks++;
    if ({collision_detected, enemy_choice, player_turn} !== {1'b1, e.ec, 1'b1}) begin
      failures++;
      $display("FAIL mid_strike_start: coll=%b ec=%b pt=%b expected 1 %b 1", collision_detected, enemy_choice, player_turn, e.ec);
    end
    @(negedge clk);
    rst = 1'b1; sprite_contact = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({state_dbg, collision_detected, player_choice, enemy_choice, player_turn, attacker_turn, turn_count, game_over}
        !== {3'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid_strike: state=%0d coll=%b pc=%b ec=%b pt=%b at=%b tc=%0d go=%b expected all 0",
               state_dbg, collision_detected, player_choice, enemy_choice, player_turn, attacker_turn, turn_count, game_over);
    end
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (collision_detected !== 1'b0 || state_dbg !== 3'd0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL post_reset_quiet: stray strike or state change=1 expected 0");
    end
  endtask

  task automatic test_back_to_back();
    confirm_go(1'b0, 1'b0, 2'b00, 1'b0);
    exp_tc = 8'd0; exp_turn = 1'b1;
    for (int r = 0; r < 257; r++) begin
      enemy_remained_sword       = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'd3;
      enemy_remained_baseballbat = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'd3;
      confirm_go(1'b1, 1'b0, 2'b00, exp_turn);
      run_strike(-1);
      check_round();
    end
    checks++;
    if (turn_count !== 8'hFF) begin
      failures++;
      $display("FAIL turn_count_saturate: tc=%0d expected 255", turn_count);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; btn_select = 1'b0; btn_confirm = 1'b0; sprite_contact = 1'b0;
    player_win = 1'b0; enemy_win = 1'b0;
    player_remained_sword = 5'd5; player_remained_baseballbat = 5'd5;
    enemy_remained_sword = 5'd5; enemy_remained_baseballbat = 5'd5;
    exp_tc = 8'd0; exp_turn = 1'b0; exp_pc = 2'b00;
    test_reset();
    test_first_strike();
    test_select_skip();
    test_same_cycle();
    test_enemy_zero_ammo();
    test_timeout();
    test_win();
    test_reset_mid_strike();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
